// File: rtl/fft_r2dit_mc.sv
// Multi-channel in-place radix-2 DIT FFT/IFFT.
// Bit-reversed load, one butterfly per cycle, natural-order unload.
module fft_r2dit_mc #(
  parameter int N    = 256,
  parameter int LOGN = 8,
  parameter int DW   = 16,
  parameter int TW   = 16,
  parameter int NCH  = 4,
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inv,
  input  logic signed [DW-1:0] s_re,
  input  logic signed [DW-1:0] s_im,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic signed [DW-1:0] m_re,
  output logic signed [DW-1:0] m_im,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [CW-1:0]        m_ch,
  output logic [LOGN-1:0]      m_bin,
  output logic                 m_last,
  output logic                 busy
);

  localparam int HN = N / 2;
  localparam int JW = LOGN - 1;
  localparam int SW = $clog2(LOGN);
  localparam int PW = DW + TW + 1;
  localparam int BW = DW + 3;
  localparam real PI = 3.14159265358979323846;
  localparam logic signed [PW-1:0] HALF = PW'(1) <<< (TW - 2);
  localparam logic signed [BW-1:0] MAXV = BW'((2 ** (DW - 1)) - 1);
  localparam logic signed [BW-1:0] MINV = BW'(-(2 ** (DW - 1)));

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  state_t state;

  logic signed [DW-1:0] mem_re [NCH][N];
  logic signed [DW-1:0] mem_im [NCH][N];

  logic [LOGN-1:0] lt;
  logic [CW-1:0]   lch;
  logic [JW-1:0]   bj;
  logic [CW-1:0]   bch;
  logic [SW-1:0]   bst;
  logic            inv_q;

  function automatic logic signed [TW-1:0] qtw(input real x);
    real y;
    y = x * real'((2 ** (TW - 1)) - 1);
    if (y >= 0.0) return TW'($rtoi(y + 0.5));
    else return -TW'($rtoi(0.5 - y));
  endfunction

  function automatic logic [LOGN-1:0] brev(input logic [LOGN-1:0] x);
    for (int i = 0; i < LOGN; i++) brev[i] = x[LOGN-1-i];
  endfunction

  function automatic logic signed [DW-1:0] sat(
    input logic signed [BW-1:0] x
  );
    logic signed [BW-1:0] y;
    y = x >>> 1;
    if (y > MAXV) y = MAXV;
    else if (y < MINV) y = MINV;
    return DW'(y);
  endfunction

  // Quarter-wave folding is not worth it here: the ROM is constant.
  logic signed [TW-1:0] cos_rom [HN];
  logic signed [TW-1:0] sin_rom [HN];

  for (genvar k = 0; k < HN; k++) begin : g_tw
    localparam real ANG = 2.0 * PI * k / N;
    assign cos_rom[k] = qtw($cos(ANG));
    assign sin_rom[k] = qtw($sin(ANG));
  end

  logic                 load_fire;
  logic [JW-1:0]        msk;
  logic [JW-1:0]        tk;
  logic [LOGN-1:0]      top;
  logic [LOGN-1:0]      bot;
  logic signed [TW-1:0] wr, wi;
  logic signed [DW-1:0] ar, ai, br, bi;
  logic signed [PW-1:0] pr, pi;
  logic signed [PW-1:0] rr, ri;
  logic signed [BW-1:0] tr, ti;
  logic signed [DW-1:0] up_re, up_im, dn_re, dn_im;

  assign s_ready   = rst_n && (state == LOAD);
  assign busy      = (state != LOAD);
  assign load_fire = s_valid && s_ready;

  always_comb begin
    msk = (JW'(1) << bst) - JW'(1);
    top = (LOGN'(bj & ~msk) << 1) | LOGN'(bj & msk);
    bot = top | (LOGN'(1) << bst);
    tk  = (bj & msk) << (SW'(LOGN - 1) - bst);
    wr  = cos_rom[tk];
    wi  = inv_q ? sin_rom[tk] : -sin_rom[tk];
    ar  = mem_re[bch][top];
    ai  = mem_im[bch][top];
    br  = mem_re[bch][bot];
    bi  = mem_im[bch][bot];
    pr  = PW'(br) * PW'(wr) - PW'(bi) * PW'(wi);
    pi  = PW'(br) * PW'(wi) + PW'(bi) * PW'(wr);
    rr  = (pr + HALF) >>> (TW - 1);
    ri  = (pi + HALF) >>> (TW - 1);
    tr  = BW'(rr);
    ti  = BW'(ri);
    up_re = sat(BW'(ar) + tr);
    up_im = sat(BW'(ai) + ti);
    dn_re = sat(BW'(ar) - tr);
    dn_im = sat(BW'(ai) - ti);
  end

  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem_re[lch][brev(lt)] <= s_re;
      mem_im[lch][brev(lt)] <= s_im;
    end
    if (state == COMPUTE) begin
      mem_re[bch][top] <= up_re;
      mem_im[bch][top] <= up_im;
      mem_re[bch][bot] <= dn_re;
      mem_im[bch][bot] <= dn_im;
    end
  end

  logic [CW-1:0]   nch;
  logic [LOGN-1:0] nbin;

  always_comb begin
    nbin = m_bin + LOGN'(1);
    nch  = (m_bin == LOGN'(N - 1)) ? m_ch + CW'(1) : m_ch;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= LOAD;
      lt      <= '0;
      lch     <= '0;
      bj      <= '0;
      bch     <= '0;
      bst     <= '0;
      inv_q   <= 1'b0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_re    <= '0;
      m_im    <= '0;
      m_ch    <= '0;
      m_bin   <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          if (load_fire) begin
            if (lt == '0 && lch == '0) inv_q <= inv;
            if (lch == CW'(NCH - 1)) begin
              lch <= '0;
              lt  <= lt + LOGN'(1);
              if (lt == LOGN'(N - 1)) state <= COMPUTE;
            end else begin
              lch <= lch + CW'(1);
            end
          end
        end
        COMPUTE: begin
          bj <= bj + JW'(1);
          if (bj == JW'(HN - 1)) begin
            if (bch == CW'(NCH - 1)) begin
              bch <= '0;
              if (bst == SW'(LOGN - 1)) begin
                // Bin 0 of ch0 is final well before the last butterfly.
                bst     <= '0;
                state   <= UNLOAD;
                m_valid <= 1'b1;
                m_last  <= 1'b0;
                m_ch    <= '0;
                m_bin   <= '0;
                m_re    <= mem_re[0][0];
                m_im    <= mem_im[0][0];
              end else begin
                bst <= bst + SW'(1);
              end
            end else begin
              bch <= bch + CW'(1);
            end
          end
        end
        UNLOAD: begin
          if (m_ready) begin
            if (m_last) begin
              state   <= LOAD;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              m_ch    <= '0;
              m_bin   <= '0;
            end else begin
              m_ch   <= nch;
              m_bin  <= nbin;
              m_re   <= mem_re[nch][nbin];
              m_im   <= mem_im[nch][nbin];
              m_last <= (nch == CW'(NCH - 1)) &&
                        (nbin == LOGN'(N - 1));
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_r2dit_mc.sv
// Directed + random frames for fft_r2dit_mc against a direct
// floating-point DFT reference.
module tb_fft_r2dit_mc;

  localparam int N    = 256;
  localparam int LOGN = 8;
  localparam int DW   = 16;
  localparam int TW   = 16;
  localparam int NCH  = 4;
  localparam int CW   = 2;
  localparam int TOT  = NCH * N;
  localparam int CBND = LOGN * (NCH * N / 2 + 8);
  localparam real PI  = 3.14159265358979323846;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 inv = 1'b0;
  logic signed [DW-1:0] s_re = '0;
  logic signed [DW-1:0] s_im = '0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic signed [DW-1:0] m_re, m_im;
  logic                 m_valid;
  logic                 m_ready = 1'b0;
  logic [CW-1:0]        m_ch;
  logic [LOGN-1:0]      m_bin;
  logic                 m_last;
  logic                 busy;

  fft_r2dit_mc #(
    .N(N), .LOGN(LOGN), .DW(DW), .TW(TW), .NCH(NCH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .inv(inv),
    .s_re(s_re), .s_im(s_im),
    .s_valid(s_valid), .s_ready(s_ready),
    .m_re(m_re), .m_im(m_im),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_ch(m_ch), .m_bin(m_bin),
    .m_last(m_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  failures = 0;
  int  in_re [NCH][N];
  int  in_im [NCH][N];
  int  org_re [NCH][N];
  int  org_im [NCH][N];
  int  out_re [NCH][N];
  int  out_im [NCH][N];
  int  kp_re [NCH][N];
  int  kp_im [NCH][N];
  real ref_re [NCH][N];
  real ref_im [NCH][N];
  real ctab [N];
  real stab [N];

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag,
                         input logic signed [31:0] obs,
                         input logic signed [31:0] lo,
                         input logic signed [31:0] hi);
    checks++;
    assert ((obs >= lo && obs <= hi) === 1'b1) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=[%0d,%0d]",
             tag, obs, lo, hi);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Direct DFT scaled by 1/N; inverse uses the conjugate kernel.
  task automatic model(input bit inv_m);
    real sr, si, c, s;
    int  ix;
    for (int ch = 0; ch < NCH; ch++)
      for (int k = 0; k < N; k++) begin
        sr = 0.0;
        si = 0.0;
        for (int t = 0; t < N; t++) begin
          ix = (k * t) % N;
          c  = ctab[ix];
          s  = inv_m ? stab[ix] : -stab[ix];
          sr += in_re[ch][t] * c - in_im[ch][t] * s;
          si += in_re[ch][t] * s + in_im[ch][t] * c;
        end
        ref_re[ch][k] = sr / N;
        ref_im[ch][k] = si / N;
      end
  endtask

  task automatic check_model(input int tol);
    int er, ei;
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < N; k++) begin
        er = int'(ref_re[c][k]);
        ei = int'(ref_im[c][k]);
        chk_rng($sformatf("re c%0d k%0d", c, k),
                out_re[c][k], er - tol, er + tol);
        chk_rng($sformatf("im c%0d k%0d", c, k),
                out_im[c][k], ei - tol, ei + tol);
      end
  endtask

  task automatic load_frame(input bit inv_f);
    int g;
    for (int t = 0; t < N; t++)
      for (int c = 0; c < NCH; c++) begin
        s_valid = 1'b1;
        s_re = DW'(in_re[c][t]);
        s_im = DW'(in_im[c][t]);
        inv = (t == 0 && c == 0) ? inv_f : 1'($urandom_range(0, 1));
        g = 0;
        while (s_ready !== 1'b1 && g < 50) begin
          step();
          g++;
        end
        if (t == 0 && c == 0) chk("s_ready_load", s_ready, 1);
        step();
      end
    // Junk held valid through COMPUTE must be ignored.
    s_re = DW'($urandom);
    s_im = DW'($urandom);
  endtask

  task automatic wait_compute();
    int cyc;
    cyc = 0;
    chk("busy_compute", busy, 1);
    chk("s_ready_compute", s_ready, 0);
    while (m_valid !== 1'b1 && cyc < CBND + 20) begin
      step();
      cyc++;
    end
    chk_rng("compute_cycles", cyc, 1, CBND);
    s_valid = 1'b0;
  endtask

  task automatic collect(input int duty, input int stop_at);
    int hs, cyc, nlast;
    bit stalled, rdy;
    logic signed [DW-1:0] h_re, h_im;
    logic [CW-1:0]        h_ch;
    logic [LOGN-1:0]      h_bin;
    logic                 h_last;
    hs = 0;
    cyc = 0;
    nlast = 0;
    stalled = 0;
    while (hs < TOT && cyc < 20000) begin
      chk("m_valid_unload", m_valid, 1);
      if (stalled) begin
        chk("hold_re", m_re, h_re);
        chk("hold_im", m_im, h_im);
        chk("hold_ch", m_ch, h_ch);
        chk("hold_bin", m_bin, h_bin);
        chk("hold_last", m_last, h_last);
      end
      rdy = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
      m_ready = rdy;
      if (m_valid === 1'b1 && rdy) begin
        chk("m_ch", m_ch, hs / N);
        chk("m_bin", m_bin, hs % N);
        chk("m_last", m_last, (hs == TOT - 1) ? 1 : 0);
        if (m_last === 1'b1) nlast++;
        out_re[hs / N][hs % N] = m_re;
        out_im[hs / N][hs % N] = m_im;
        hs++;
        stalled = 0;
      end else begin
        stalled = 1;
        h_re = m_re;
        h_im = m_im;
        h_ch = m_ch;
        h_bin = m_bin;
        h_last = m_last;
      end
      step();
      cyc++;
      if (stop_at > 0 && hs == stop_at) break;
    end
    m_ready = 1'b0;
    if (stop_at == 0) begin
      chk("handshakes", hs, TOT);
      chk("m_last_count", nlast, 1);
      chk("m_valid_after", m_valid, 0);
      chk("busy_after", busy, 0);
      chk("s_ready_after", s_ready, 1);
    end
  endtask

  task automatic run_frame(input bit inv_f, input int duty);
    load_frame(inv_f);
    wait_compute();
    collect(duty, 0);
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    step();
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_s_ready_low"}, s_ready, 0);
    rst_n = 1'b1;
    step();
    chk({tag, "_s_ready_high"}, s_ready, 1);
  endtask

  task automatic gen_const(input int re, input int im);
    for (int c = 0; c < NCH; c++)
      for (int t = 0; t < N; t++) begin
        in_re[c][t] = re;
        in_im[c][t] = im;
      end
  endtask

  task automatic gen_rand();
    for (int c = 0; c < NCH; c++)
      for (int t = 0; t < N; t++) begin
        in_re[c][t] = int'($urandom_range(0, 32766)) - 16383;
        in_im[c][t] = int'($urandom_range(0, 32766)) - 16383;
      end
  endtask

  task automatic dc_checks();
    for (int c = 0; c < NCH; c++)
      chk_rng($sformatf("dc_bin0 c%0d", c), out_re[c][0],
              8192 - LOGN, 8192);
    check_model(LOGN);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      ctab[i] = $cos(2.0 * PI * i / N);
      stab[i] = $sin(2.0 * PI * i / N);
    end

    repeat (3) step();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_re", m_re, 0);
    chk("rst_m_im", m_im, 0);
    chk("rst_m_ch", m_ch, 0);
    chk("rst_m_bin", m_bin, 0);
    rst_n = 1'b1;
    step();
    chk("s_ready_release", s_ready, 1);

    gen_const(8192, 0);
    model(1'b0);
    run_frame(1'b0, 100);
    dc_checks();

    for (int c = 0; c < NCH; c++)
      for (int t = 0; t < N; t++) begin
        in_re[c][t] = int'(ctab[((8 + c) * t) % N] * 8192.0);
        in_im[c][t] = 0;
      end
    model(1'b0);
    run_frame(1'b0, 100);
    check_model(LOGN);
    for (int c = 0; c < NCH; c++) begin
      chk_rng($sformatf("tone_lo c%0d", c), out_re[c][8 + c],
              4096 - 16, 4096 + 16);
      chk_rng($sformatf("tone_hi c%0d", c), out_re[c][N - 8 - c],
              4096 - 16, 4096 + 16);
    end

    gen_rand();
    org_re = in_re;
    org_im = in_im;
    model(1'b0);
    run_frame(1'b0, 100);
    check_model(LOGN);
    kp_re = out_re;
    kp_im = out_im;

    run_frame(1'b0, 30);
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < N; k++) begin
        chk($sformatf("bp_re c%0d k%0d", c, k), out_re[c][k],
            kp_re[c][k]);
        chk($sformatf("bp_im c%0d k%0d", c, k), out_im[c][k],
            kp_im[c][k]);
      end

    in_re = kp_re;
    in_im = kp_im;
    run_frame(1'b1, 100);
    for (int c = 0; c < NCH; c++)
      for (int t = 0; t < N; t++) begin
        int er, ei;
        er = int'(real'(org_re[c][t]) / N);
        ei = int'(real'(org_im[c][t]) / N);
        chk_rng($sformatf("rt_re c%0d t%0d", c, t), out_re[c][t],
                er - (LOGN + 1), er + (LOGN + 1));
        chk_rng($sformatf("rt_im c%0d t%0d", c, t), out_im[c][t],
                ei - (LOGN + 1), ei + (LOGN + 1));
      end

    gen_rand();
    load_frame(1'b0);
    s_valid = 1'b0;
    repeat (100) step();
    chk("busy_mid_compute", busy, 1);
    pulse_reset("rst_compute");

    load_frame(1'b0);
    wait_compute();
    collect(100, 100);
    pulse_reset("rst_unload");

    gen_const(8192, 0);
    model(1'b0);
    run_frame(1'b0, 100);
    dc_checks();

    gen_const(32767, 32767);
    model(1'b0);
    run_frame(1'b0, 100);
    chk_rng("sat_bin0_re", out_re[0][0], 32767 - LOGN, 32767);
    chk_rng("sat_bin0_im", out_im[0][0], 32767 - LOGN, 32767);
    check_model(LOGN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_r2dit_mc.md
FFT_R2DIT_MC -- requirements
Module: fft_r2dit_mc

Interface
REQ-001 SHALL have parameter N, default 256, FFT length (power of 2, 8..1024).
REQ-002 SHALL have parameter LOGN, default 8, log2(N).
REQ-003 SHALL have parameter DW, default 16, signed sample width (re and im).
REQ-004 SHALL have parameter TW, default 16, signed twiddle width, Q1.(TW-1).
REQ-005 SHALL have parameter NCH, default 4, number of array channels.
REQ-006 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-007 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-008 SHALL have port inv  in  1  1 = inverse transform; sampled on the first accepted beat of a frame.
REQ-009 SHALL have port s_re, s_im  in  DW each  complex input sample.
REQ-010 SHALL have port s_valid / s_ready  in / out  1 each  input handshake; a beat transfers when both are high.
REQ-011 SHALL have port m_re, m_im  out  DW each  complex output bin.
REQ-012 SHALL have port m_valid / m_ready  out / in  1 each  output handshake.
REQ-013 SHALL have port m_ch  out  clog2(NCH)  channel of current output.
REQ-014 SHALL have port m_bin  out  LOGN  bin index of current output.
REQ-015 SHALL have port m_last  out  1  high on the final output beat of a frame.
REQ-016 SHALL have port busy  out  1  high in COMPUTE or UNLOAD.

Function
REQ-017 SHALL implement FSM LOAD -> COMPUTE -> UNLOAD -> LOAD.
- LOAD -> COMPUTE after NCH*N accepted beats.
- COMPUTE -> UNLOAD after the final butterfly of the final stage is written.
- UNLOAD -> LOAD on the handshake of the m_last beat.
REQ-018 Input beats SHALL be time-interleaved: sample t of ch0..ch(NCH-1), then t+1; each beat is written to its channel buffer at bit-reversed address of t.
REQ-019 s_ready SHALL be 1 only in LOAD; s_valid outside LOAD SHALL be ignored and leave state unchanged.
REQ-020 COMPUTE SHALL perform LOGN in-place radix-2 DIT stages per channel at a throughput of one butterfly per cycle; total COMPUTE cycles SHALL be <= LOGN*(NCH*N/2+8).
REQ-021 Twiddle W^k SHALL be cos(2πk/N) - j·sin(2πk/N), with k = 0..N/2-1, taken from ROM; when inv=1 the sine term SHALL be negated (conjugate).
- Value +1.0 SHALL be coded as 2^(TW-1)-1.
REQ-022 Complex multiply SHALL use full precision, then round half-up to DW at TW-1 fractional bits.
REQ-023 Each butterfly output (a±bW) SHALL be arithmetically shifted right by 1 (floor), then saturated to [-2^(DW-1), 2^(DW-1)-1]; net scaling is 1/N for both directions.
REQ-024 UNLOAD SHALL emit channel-major, natural order: ch0 bins 0..N-1, then ch1, and so on; m_ch and m_bin SHALL match each beat.
REQ-025 While m_valid=1 and m_ready=0, m_re, m_im, m_ch, m_bin and m_last SHALL hold stable.
REQ-026 m_valid SHALL remain high through UNLOAD until the last handshake, including in the same cycle m_ready rises.
REQ-027 s_ready SHALL rise in the cycle after the m_last handshake; LOAD of the next frame and UNLOAD SHALL never overlap.
REQ-028 The inv value SHALL be latched once per frame; changes of inv mid-frame SHALL have no effect.

Reset
REQ-029 With rst_n=0 at a clock edge: state = LOAD, all counters = 0, and s_ready=0 during reset.
- Outputs SHALL reset to m_valid=0, m_last=0, busy=0, m_re=m_im=0, m_ch=0, m_bin=0.
REQ-030 After reset release, s_ready SHALL be 1 in the first cycle.
REQ-031 Reset asserted in any state SHALL discard the partial frame; the next accepted beat is t=0, ch0.
- Buffer contents need not be cleared.

Verification
REQ-032 DC test: all channels s_re=8192, s_im=0, inv=0, N=256, m_ready=1 -> bin0 ∈ [8192-LOGN, 8192], all other bins |re|,|im| <= LOGN, for every channel.
REQ-033 Tone test: ch c gets cos(2π·(8+c)·t/N)·8192 -> ch c peaks at bins 8+c and N-8-c with re ≈ 4096±16; all other bins <= 16.
REQ-034 Round-trip test: FFT output fed back with inv=1, random input with |x| < 2^(DW-2) -> result equals x/N ±(LOGN+1) LSB.
REQ-035 Backpressure test: random m_ready at 30% duty -> output identical to the m_ready=1 run; data stable while stalled; exactly NCH*N handshakes; one m_last.
REQ-036 Reset test: rst_n pulse during COMPUTE, then during UNLOAD at beat 100 -> m_valid=0 and busy=0 next cycle, s_ready=1 after release; a following DC frame still passes REQ-032.
REQ-037 Saturation test: s_re=s_im=32767 on all beats -> no sign-flip wrap in any output; bin0 re and im ∈ [32767-LOGN, 32767].
